reset_pulse_seq: RTL
====================

Name: reset_pulse_seq

Overview:
- Multi-channel, parametrised reset pulse generator for target-board reset and power-cycle control.
- Each channel emits one reset pulse per trigger. Each pulse has a programmable pre-delay and width, both latched at trigger time.
- Supports per-channel polarity, retrigger policy, abort, a boot-time pulse, and busy/done status.
- Sits between the host command decoder and the target reset pins.

Parameters:
- CHANNELS, 2, number of independent reset channels
- CNT_W, 25, width of delay and width counters; max programmable value is 2^CNT_W-1
- ACTIVE_LOW, 2'b00, per-channel polarity; bit set means the pin is driven 0 when asserted
- RETRIGGER, 1, 1: a trigger while busy restarts the sequence; 0: a trigger while busy is ignored
- BOOT_MASK, 2'b00, channels that start an automatic pulse when rst_n releases
- BOOT_WIDTH, 21_900_000, width of the boot pulse in cycles, with zero delay

Ports:
- clk  in  1  system clock (12 MHz)
- rst_n  in  1  asynchronous, active-low reset
- trigger  in  CHANNELS  per-channel start request, sampled on rising clk
- abort  in  CHANNELS  per-channel cancel, sampled on rising clk
- delay_cycles  in  CHANNELS*CNT_W  per-channel pre-delay D; channel i uses bits [i*CNT_W +: CNT_W]
- width_cycles  in  CHANNELS*CNT_W  per-channel pulse width W, same packing as delay_cycles
- reset_out  out  CHANNELS  registered reset pins, polarity per ACTIVE_LOW
- busy  out  CHANNELS  high while the channel is not IDLE
- done  out  CHANNELS  one-cycle pulse when a sequence completes normally

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Per-channel FSM states: IDLE, DELAY, ACTIVE. Each channel has one down-counter cnt[CNT_W-1:0]. Channels are fully independent.
- While rst_n is low:
  - Channels not in BOOT_MASK: state=IDLE, cnt=0, reset_out = inactive level, busy=0, done=0.
  - Channels in BOOT_MASK: state=ACTIVE, cnt=BOOT_WIDTH, reset_out = asserted level, busy=1, done=0.
  - After release, a boot channel stays asserted for exactly BOOT_WIDTH cycles, then completes like a normal sequence.
- Trigger accepted at edge k (IDLE, or busy with RETRIGGER=1):
  - D and W are latched at edge k. Later input changes have no effect.
  - If D>0: go to DELAY with cnt=D.
  - If D=0 and W>0: go to ACTIVE with cnt=W.
  - If D=0 and W=0: stay IDLE and pulse done in cycle k+1.
- DELAY: cnt decrements each edge. On the edge where cnt==1:
  - if W>0, load cnt=W and go to ACTIVE;
  - if W=0, go to IDLE and pulse done.
- ACTIVE: reset_out asserted. cnt decrements each edge. On the edge where cnt==1, go to IDLE, deassert reset_out, set done.
- Cycle timing, with cycle n meaning the clock period after edge n:
  - busy is high in cycles k+1 .. k+D+W.
  - reset_out is asserted in cycles k+D+1 .. k+D+W, exactly W cycles.
  - done is high only in cycle k+D+W+1.
- done:
  - Registered, one cycle wide. Never asserted by abort.
  - done and a new trigger in the same cycle is legal: the trigger is accepted from IDLE.
- Retrigger while busy with RETRIGGER=1:
  - The sequence restarts from edge k with newly latched D/W, regardless of current state.
  - If the restart enters DELAY from ACTIVE, reset_out deasserts in cycle k+1.
  - No done is issued for the interrupted sequence.
- Retrigger while busy with RETRIGGER=0: the trigger is ignored.
- abort: forces IDLE at the next edge, reset_out inactive, cnt=0, no done. abort wins over a simultaneous trigger. abort in IDLE has no effect.
- Counter arithmetic: cnt never wraps. Maximum D or W is 2^CNT_W-1. No intermediate addition is needed; D and W are loaded directly.
- Asynchronous reset mid-sequence: the channel returns immediately to its reset state, including the boot behaviour where configured.

Test Plan:
- CHANNELS=2, ACTIVE_LOW=2'b00. Ch0 trigger at edge 10 with D=3, W=5 -> reset_out[0] high in cycles 14..18, busy[0] high in cycles 11..18, done[0] high in cycle 19 only. Ch1 stays idle throughout.
- ACTIVE_LOW=2'b10. Ch1 trigger with D=0, W=1 -> reset_out[1] low for exactly 1 cycle, starting the cycle after the trigger edge. Otherwise reset_out[1] is high, including during reset.
- RETRIGGER=1. Ch0 D=0, W=10; retrigger at the 4th active cycle with D=2, W=3 -> reset_out[0] deasserts for 2 cycles, then asserts for 3. A single done follows. Repeat with RETRIGGER=0 -> the retrigger is ignored and the original 10-cycle pulse completes.
- Abort in ch0 DELAY, and abort coincident with trigger -> channel goes IDLE next edge, reset_out inactive, done never pulses.
- BOOT_MASK=2'b01, BOOT_WIDTH=100. Release rst_n -> reset_out[0] asserted from reset through exactly 100 cycles after release, then done[0] pulses. Assert rst_n mid-pulse -> the pulse restarts at a full 100 cycles.
- Edge values: D=0, W=0 -> done only, no assertion. D=W=2^CNT_W-1 with CNT_W=4 -> 15-cycle delay, then a 15-cycle pulse. Trigger in the done cycle -> accepted with no gap.

Source files
------------

// File: rtl/reset_pulse_seq_if.sv
// Host-side command bus and target-side status for the reset pulse sequencer.
// The master drives requests and per-channel timing; the slave returns pin and status levels.
interface reset_pulse_seq_if #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 25
);
  logic [CHANNELS-1:0]       trigger;
  logic [CHANNELS-1:0]       abort;
  logic [CHANNELS*CNT_W-1:0] delay_cycles;
  logic [CHANNELS*CNT_W-1:0] width_cycles;
  logic [CHANNELS-1:0]       reset_out;
  logic [CHANNELS-1:0]       busy;
  logic [CHANNELS-1:0]       done;

  modport master (
    output trigger, abort, delay_cycles, width_cycles,
    input  reset_out, busy, done
  );

  modport slave (
    input  trigger, abort, delay_cycles, width_cycles,
    output reset_out, busy, done
  );
endinterface

// File: rtl/reset_pulse_seq.sv
// Independent per-channel reset pulse generators: programmable delay then width, all outputs registered.
// A request held during cycle k takes effect at the next edge; no backpressure, requests while busy restart or are dropped.
module reset_pulse_seq #(
  parameter int                  CHANNELS   = 2,
  parameter int                  CNT_W      = 25,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW = '0,
  parameter bit                  RETRIGGER  = 1'b1,
  parameter logic [CHANNELS-1:0] BOOT_MASK  = '0,
  parameter int                  BOOT_WIDTH = 21_900_000
) (
  input  logic             clk,
  input  logic             rst_n,
  reset_pulse_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BOOT_CNT = CNT_W'(BOOT_WIDTH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t state_q [CHANNELS];
  state_t state_d [CHANNELS];

  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][CNT_W-1:0] width_q, width_d;
  logic [CHANNELS-1:0][CNT_W-1:0] d_in, w_in;
  logic [CHANNELS-1:0]            reset_out_q, reset_out_d;
  logic [CHANNELS-1:0]            busy_q, busy_d;
  logic [CHANNELS-1:0]            done_q, done_d;

  assign d_in = bus.delay_cycles;
  assign w_in = bus.width_cycles;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      width_d[i] = width_q[i];
      done_d[i]  = 1'b0;

      // Abort outranks any trigger on the same edge and never reports completion.
      if (bus.abort[i]) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else if (bus.trigger[i] && (state_q[i] == IDLE || RETRIGGER)) begin
        width_d[i] = w_in[i];
        if (d_in[i] != '0) begin
          state_d[i] = DELAY;
          cnt_d[i]   = d_in[i];
        end else if (w_in[i] != '0) begin
          state_d[i] = ACTIVE;
          cnt_d[i]   = w_in[i];
        end else begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
          done_d[i]  = 1'b1;
        end
      end else begin
        case (state_q[i])
          DELAY: begin
            if (cnt_q[i] == ONE) begin
              if (width_q[i] != '0) begin
                state_d[i] = ACTIVE;
                cnt_d[i]   = width_q[i];
              end else begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                done_d[i]  = 1'b1;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - ONE;
            end
          end
          ACTIVE: begin
            if (cnt_q[i] == ONE) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
              done_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - ONE;
            end
          end
          default: ;
        endcase
      end

      // Pin and busy follow the next state so they change on the same edge as the FSM.
      busy_d[i]      = (state_d[i] != IDLE);
      reset_out_d[i] = (state_d[i] == ACTIVE) ^ ACTIVE_LOW[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]     <= BOOT_MASK[i] ? ACTIVE : IDLE;
        cnt_q[i]       <= BOOT_MASK[i] ? BOOT_CNT : '0;
        width_q[i]     <= '0;
        reset_out_q[i] <= BOOT_MASK[i] ^ ACTIVE_LOW[i];
        busy_q[i]      <= BOOT_MASK[i];
        done_q[i]      <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
      end
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      reset_out_q <= reset_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.reset_out = reset_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
